// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive bit controller: paces line sampling, tracks runs of ones,
// strips stuffed zeros and frames the data bits between flags.
module hdlc_rx_ctrl #(
  parameter int DIV       = 4,
  parameter int RUN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_dat,
  output logic                 o_bit_vld,
  output logic                 o_bit,
  output logic                 o_sof,
  output logic                 o_eof,
  output logic                 o_abort,
  output logic                 o_sync,
  output logic [RUN_WIDTH-1:0] o_run_cnt
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
  localparam logic [RUN_WIDTH-1:0] RMAX = '1;
  localparam logic [RUN_WIDTH-1:0] R5 = RUN_WIDTH'(5);
  localparam logic [RUN_WIDTH-1:0] R6 = RUN_WIDTH'(6);

  typedef enum logic [1:0] {
    HUNT,
    FLAG,
    FRAME
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]        div_q, div_nx;
  logic [RUN_WIDTH-1:0] run, run_nx;
  logic [7:0]           pb, pb_nx;
  logic [7:0]           pv, pv_nx;
  logic                 bit_nx, vld_nx;
  logic                 sof_nx, eof_nx, abort_nx;
  logic                 tick, exit_vld;
  logic                 is_flag, is_stuff, is_abort, is_data;

  always_comb begin
    tick     = i_en && (div_q == DMAX);
    is_flag  = !i_dat && (run == R6);
    is_stuff = !i_dat && (run == R5);
    is_abort = i_dat && (run == R6);
    is_data  = !(is_flag || is_stuff || is_abort);
    exit_vld = pv[7];

    state_nx = state;
    div_nx   = div_q;
    run_nx   = run;
    pb_nx    = pb;
    pv_nx    = pv;
    bit_nx   = o_bit;
    vld_nx   = 1'b0;
    sof_nx   = 1'b0;
    eof_nx   = 1'b0;
    abort_nx = 1'b0;

    if (!i_en) begin
      state_nx = HUNT;
      div_nx   = '0;
      run_nx   = '0;
      pb_nx    = '0;
      pv_nx    = '0;
    end else begin
      div_nx = (div_q == DMAX) ? '0 : div_q + 1'b1;
      if (tick) begin
        if (!i_dat)
          run_nx = '0;
        else if (run != RMAX)
          run_nx = run + 1'b1;
        pb_nx = {pb[6:0], i_dat};
        pv_nx = {pv[6:0], is_data && (state != HUNT)};
        unique case (1'b1)
          is_abort: begin
            // abort also swallows the bit leaving the pipeline
            pv_nx = '0;
            if (state != HUNT) begin
              abort_nx = 1'b1;
              state_nx = HUNT;
            end
          end
          default: begin
            if (exit_vld) begin
              vld_nx = 1'b1;
              bit_nx = pb[7];
            end
            // a flag invalidates its own seven older bits too
            if (is_flag)
              pv_nx = '0;
            unique case (state)
              HUNT: begin
                if (is_flag)
                  state_nx = FLAG;
              end
              FLAG: begin
                if (is_flag) begin
                  sof_nx = exit_vld;
                  eof_nx = exit_vld;
                end else if (exit_vld) begin
                  sof_nx   = 1'b1;
                  state_nx = FRAME;
                end
              end
              FRAME: begin
                if (is_flag) begin
                  eof_nx   = 1'b1;
                  state_nx = FLAG;
                end
              end
              default: state_nx = HUNT;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= HUNT;
      div_q     <= '0;
      run       <= '0;
      pb        <= '0;
      pv        <= '0;
      o_bit     <= 1'b0;
      o_bit_vld <= 1'b0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      state     <= state_nx;
      div_q     <= div_nx;
      run       <= run_nx;
      pb        <= pb_nx;
      pv        <= pv_nx;
      o_bit     <= bit_nx;
      o_bit_vld <= vld_nx;
      o_sof     <= sof_nx;
      o_eof     <= eof_nx;
      o_abort   <= abort_nx;
    end
  end

  assign o_sync    = (state != HUNT);
  assign o_run_cnt = run;

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// Bench for hdlc_rx_ctrl: directed frames plus random line traffic,
// checked every clock against a history-window reference model.
module tb_hdlc_rx_ctrl;

  localparam int DIV  = 4;
  localparam int RW   = 4;
  localparam int RMAX = (1 << RW) - 1;
  localparam int HUNT = 0;
  localparam int FLG  = 1;
  localparam int FRM  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic dat   = 1'b0;
  logic bit_vld, bit_o, sof, eof, abrt, sync;
  logic [RW-1:0] run_cnt;

  hdlc_rx_ctrl #(
    .DIV(DIV),
    .RUN_WIDTH(RW)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_dat(dat),
    .o_bit_vld(bit_vld),
    .o_bit(bit_o),
    .o_sof(sof),
    .o_eof(eof),
    .o_abort(abrt),
    .o_sync(sync),
    .o_run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: sampled-bit history and per-bit survival flags
  int mst;
  int ecyc;
  int sb[$];
  int cd[$];
  int e_vld, e_bit, e_sof, e_eof, e_ab, e_run;
  int m_nvld;

  task automatic model_clear();
    mst = HUNT;
    ecyc = 0;
    sb.delete();
    cd.delete();
    e_run = 0;
  endtask

  task automatic model_reset();
    model_clear();
    e_bit = 0;
  endtask

  task automatic tick_model(input int b);
    int n, run, exitv, exitb;
    bit flag, stuff, ab, data;
    n = sb.size();
    run = 0;
    for (int i = n - 1; i >= 0 && sb[i] == 1 && run < RMAX; i--)
      run++;
    flag  = (b == 0) && (run == 6);
    stuff = (b == 0) && (run == 5);
    ab    = (b == 1) && (run == 6);
    data  = !flag && !stuff && !ab;
    exitv = (n >= 8) ? cd[n-8] : 0;
    exitb = (n >= 8) ? sb[n-8] : 0;
    sb.push_back(b);
    cd.push_back((data && mst != HUNT) ? 1 : 0);
    if (flag)
      for (int j = n - 7; j <= n; j++)
        if (j >= 0) cd[j] = 0;
    if (ab)
      foreach (cd[j]) cd[j] = 0;
    while (sb.size() > 16) begin
      void'(sb.pop_front());
      void'(cd.pop_front());
    end
    e_run = b ? ((run + 1 > RMAX) ? RMAX : run + 1) : 0;
    if (ab) begin
      if (mst != HUNT) begin
        e_ab = 1;
        mst = HUNT;
      end
    end else begin
      if (exitv != 0) begin
        e_vld = 1;
        e_bit = exitb;
        m_nvld++;
      end
      case (mst)
        HUNT: if (flag) mst = FLG;
        FLG: begin
          if (flag) begin
            e_sof = exitv;
            e_eof = exitv;
          end else if (exitv != 0) begin
            e_sof = 1;
            mst = FRM;
          end
        end
        default: begin
          if (flag) begin
            e_eof = 1;
            mst = FLG;
          end
        end
      endcase
    end
  endtask

  // monitor bookkeeping per scenario
  int stepn = 0;
  int got[$];
  int exp_q[$];
  int n_sof, n_eof, n_ab;
  int first_vld, last_vld, prev_vld, eof_at, sof_at, gap_bad;

  task automatic clr_mon();
    got.delete();
    n_sof = 0;
    n_eof = 0;
    n_ab = 0;
    first_vld = -1;
    last_vld = -1;
    prev_vld = -1;
    eof_at = -1;
    sof_at = -1;
    gap_bad = 0;
    m_nvld = 0;
  endtask

  task automatic step(input logic e, input logic d);
    en = e;
    dat = d;
    @(posedge clk);
    stepn++;
    e_vld = 0;
    e_sof = 0;
    e_eof = 0;
    e_ab = 0;
    if (!e) begin
      model_clear();
    end else begin
      if (ecyc % DIV == DIV - 1) tick_model(int'(d));
      ecyc++;
    end
    #1;
    chk("bit_vld", bit_vld, e_vld);
    chk("bit", bit_o, e_bit);
    chk("sof", sof, e_sof);
    chk("eof", eof, e_eof);
    chk("abort", abrt, e_ab);
    chk("sync", sync, (mst != HUNT) ? 1 : 0);
    chk("run_cnt", run_cnt, e_run);
    if (bit_vld) begin
      got.push_back(int'(bit_o));
      if (first_vld < 0) first_vld = stepn;
      if (prev_vld >= 0 && stepn - prev_vld != DIV) gap_bad++;
      prev_vld = stepn;
      last_vld = stepn;
    end
    if (sof) begin
      n_sof++;
      sof_at = stepn;
    end
    if (eof) begin
      n_eof++;
      eof_at = stepn;
    end
    if (abrt) n_ab++;
  endtask

  task automatic send_bit(input logic b);
    repeat (DIV) step(1'b1, b);
  endtask

  task automatic send_flag();
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit(1'b0);
  endtask

  task automatic send_raw(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic check_bits(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got.size()) ? got[i] : -1, exp_q[i]);
  endtask

  initial begin
    int samp, tx_ones, nb, r;
    logic b;
    model_reset();
    clr_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", int'({bit_vld, bit_o, sof, eof, abrt, sync, run_cnt}), 0);
    rst_n = 1'b1;

    // asynchronous reset in the middle of a bit period
    send_flag();
    repeat (3) send_bit(1'b1);
    chk("pre_rst_sync", sync, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", int'({bit_vld, bit_o, sof, eof, abrt, sync, run_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_bit(1'b1);
    chk("rst_run1", run_cnt, 1);

    // basic frame
    send_flag();
    clr_mon();
    send_bit(1'b1);
    samp = stepn;
    send_raw(32'b0100101, 7);
    send_flag();
    exp_q = '{1, 0, 1, 0, 0, 1, 0, 1};
    check_bits("basic_bits");
    chk("basic_sof_n", n_sof, 1);
    chk("basic_eof_n", n_eof, 1);
    chk("basic_sof_first", sof_at, first_vld);
    chk("basic_eof_last", eof_at, last_vld);
    chk("basic_latency", first_vld - samp, 8 * DIV);
    chk("basic_spacing", gap_bad, 0);

    // stuffed zero removed
    clr_mon();
    send_raw(32'b11111010, 8);
    send_flag();
    exp_q = '{1, 1, 1, 1, 1, 1, 0};
    check_bits("stuff_bits");
    chk("stuff_eof_n", n_eof, 1);

    // abort after a short frame
    clr_mon();
    send_flag();
    send_raw(32'b10, 2);
    repeat (20) send_bit(1'b1);
    chk("abort_n", n_ab, 1);
    chk("abort_eof_n", n_eof, 0);
    chk("abort_sync", sync, 0);
    chk("abort_run_sat", run_cnt, RMAX);
    chk("abort_bits", got.size(), m_nvld);

    // shared-zero and idle flags carry no data
    clr_mon();
    send_raw(32'b0111111011111101111110, 22);
    chk("shared_sync", sync, 1);
    chk("shared_bits", got.size(), 0);
    chk("shared_sof_n", n_sof, 0);
    chk("shared_eof_n", n_eof, 0);

    // disable mid-frame, then resynchronise
    clr_mon();
    send_flag();
    send_raw(32'b1011, 4);
    step(1'b0, 1'b0);
    chk("dis_sync", sync, 0);
    chk("dis_eof_n", n_eof, 0);
    chk("dis_bits", got.size(), 0);
    clr_mon();
    send_flag();
    send_raw(32'b01101001, 8);
    send_flag();
    exp_q = '{0, 1, 1, 0, 1, 0, 0, 1};
    check_bits("resync_bits");
    chk("resync_sof_n", n_sof, 1);
    chk("resync_eof_n", n_eof, 1);

    // random stuffed frames with aborts and disables
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      send_flag();
      tx_ones = 0;
      nb = $urandom_range(0, 30);
      for (int i = 0; i < nb; i++) begin
        b = 1'($urandom % 2);
        send_bit(b);
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == 5) begin
          send_bit(1'b0);
          tx_ones = 0;
        end
      end
      if (r == 0)
        repeat (8) send_bit(1'b1);
      else if (r == 1)
        step(1'b0, 1'b0);
      else
        send_flag();
      repeat ($urandom_range(0, 3)) send_bit(1'b1);
    end

    // raw line noise biased towards ones
    for (int i = 0; i < 300; i++)
      send_bit(($urandom % 4) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
